// File: rtl/stream_rr_arbiter.sv
// Round-robin merge of NREQ valid/ready byte streams into one registered, source-tagged stream.
// Latency: one cycle for arbitration, one cycle input-to-output; iready is the only path from oready.
module stream_rr_arbiter #(
    parameter int DSIZE = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 16,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       ivalid,
    output logic [NREQ-1:0]       iready,
    input  logic [NREQ*DSIZE-1:0] idata,
    output logic                  ovalid,
    input  logic                  oready,
    output logic [DSIZE-1:0]      odata,
    output logic [IDW-1:0]        oid
);

    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovalid_q, ovalid_d;
    logic [DSIZE-1:0] odata_q, odata_d;
    logic [IDW-1:0]   oid_q, oid_d;

    logic             load;
    logic             gvalid;
    logic             accept;
    logic [IDW-1:0]   pick;

    assign load   = ~ovalid_q | oready;
    assign gvalid = ivalid[grant_q];

    // Search starts just after the last released requester so it ends up lowest priority.
    always_comb begin
        int  idx;
        logic found;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last_q) + i) % NREQ;
            if (!found && ivalid[idx]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        ovalid_d = ovalid_q;
        odata_d  = odata_q;
        oid_d    = oid_q;
        iready   = '0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (oready) begin
                    ovalid_d = 1'b0;
                end
                if (|ivalid) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                iready[grant_q] = load;
                accept          = gvalid & load;
                if (accept) begin
                    odata_d  = idata[int'(grant_q)*DSIZE +: DSIZE];
                    oid_d    = grant_q;
                    ovalid_d = 1'b1;
                end else if (oready) begin
                    ovalid_d = 1'b0;
                end
                // Counter is held on the final beat so it never wraps.
                if ((accept && cnt_q == CW'(BURST-1)) || !gvalid) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end else if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= IDW'(NREQ-1);
            cnt_q    <= '0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            oid_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            oid_q    <= oid_d;
        end
    end

    assign ovalid = ovalid_q;
    assign odata  = odata_q;
    assign oid    = oid_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level arbitration model and a per-source payload order scoreboard.
module tb_stream_rr_arbiter;

    localparam int DSIZE = 8;
    localparam int NREQ  = 4;
    localparam int BURST = 4;
    localparam int IDW   = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rstn;
    logic [NREQ-1:0]       ivalid;
    logic [NREQ-1:0]       iready;
    logic [NREQ*DSIZE-1:0] idata;
    logic                  ovalid;
    logic                  oready;
    logic [DSIZE-1:0]      odata;
    logic [IDW-1:0]        oid;

    stream_rr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .BURST(BURST)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .ivalid (ivalid),
        .iready (iready),
        .idata  (idata),
        .ovalid (ovalid),
        .oready (oready),
        .odata  (odata),
        .oid    (oid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the output, how many beats it has taken, who was released last.
    bit         chk_en = 0;
    bit         m_busy;
    int         m_owner, m_last, m_taken;
    bit         m_ov;
    logic [7:0] m_od;
    int         m_oid;

    // Traffic generators and scoreboard.
    bit  v[NREQ];
    int  seq[NREQ];
    int  left[NREQ];
    int  outcnt[NREQ];
    int  oid_log[$];
    int  prob = 100;
    int  drop = 0;
    int  ord_mode = 1;
    int  cyc = 0;

    function automatic logic [7:0] beat_val(input int k, input int s);
        return 8'((k << 4) | (s & 15));
    endfunction

    task automatic step();
        logic            r;
        logic [NREQ-1:0] acc;
        logic [31:0]     exp_ir;
        bit              ld, accb;
        int              best, k;
        @(negedge clk);
        r   = rstn;
        acc = iready & ivalid;
        if (chk_en) begin
            ld     = !m_ov || oready;
            exp_ir = (m_busy && ld) ? (32'd1 << m_owner) : 32'd0;
            check_eq("iready", 32'(iready), exp_ir);
            check_eq("ovalid", 32'(ovalid), 32'(m_ov));
            check_eq("odata", 32'(odata), 32'(m_od));
            check_eq("oid", 32'(oid), 32'(m_oid));
            if (r && ovalid === 1'b1 && oready) begin
                k = int'(oid);
                if (k < NREQ) begin
                    check_eq("payload", 32'(odata), 32'(beat_val(k, outcnt[k])));
                    outcnt[k]++;
                end
                oid_log.push_back(k);
            end
        end
        if (!r) begin
            m_busy = 0; m_owner = 0; m_last = NREQ-1; m_taken = 0;
            m_ov = 0; m_od = '0; m_oid = 0;
            chk_en = 1;
        end else if (!m_busy) begin
            if (oready) m_ov = 0;
            best = -1;
            for (int d = 1; d <= NREQ; d++)
                if (best < 0 && ivalid[(m_last + d) % NREQ]) best = (m_last + d) % NREQ;
            if (best >= 0) begin
                m_busy = 1; m_owner = best; m_taken = 0;
            end
        end else begin
            ld   = !m_ov || oready;
            accb = ivalid[m_owner] && ld;
            if (accb) begin
                m_od = idata[m_owner*DSIZE +: DSIZE];
                m_oid = m_owner; m_ov = 1; m_taken++;
            end else if (oready) begin
                m_ov = 0;
            end
            if ((accb && m_taken == BURST) || !ivalid[m_owner]) begin
                m_busy = 0; m_last = m_owner;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NREQ; i++) begin
            if (r && acc[i]) begin
                seq[i]++;
                if (left[i] > 0) left[i]--;
                v[i] = 0;
            end else if (v[i] && drop > 0 && $urandom_range(99) < drop) begin
                v[i] = 0;
            end
            if (!v[i] && left[i] > 0 && $urandom_range(99) < prob) v[i] = 1;
            if (!r) outcnt[i] = seq[i];
            ivalid[i]           = v[i];
            idata[i*DSIZE +: DSIZE] = beat_val(i, seq[i]);
        end
        case (ord_mode)
            0:       oready = 1'b0;
            2:       oready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            3:       oready = ($urandom_range(99) < 70);
            default: oready = 1'b1;
        endcase
    endtask

    task automatic drain();
        int n = 0;
        ord_mode = 1;
        for (int i = 0; i < NREQ; i++) left[i] = 0;
        while ((ivalid != '0 || ovalid !== 1'b0) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) check_eq("drain_timeout", 32'd1, 32'd0);
        repeat (3) step();
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    initial begin
        rstn   = 1'b0;
        oready = 1'b1;
        ivalid = '0;
        idata  = '0;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 0; seq[i] = 0; left[i] = 0; outcnt[i] = 0;
        end
        // Reset and quiet hold.
        step();
        step();
        rstn = 1'b1;
        repeat (5) step();
        check_eq("idle_iready", 32'(iready), 32'd0);

        // All four streaming continuously: bursts of BURST in index order.
        oid_log.delete();
        prob = 100;
        for (int i = 0; i < NREQ; i++) left[i] = 8;
        repeat (60) step();
        drain();
        if (oid_log.size() < 16) check_eq("rr_log_size", 32'(oid_log.size()), 32'd16);
        else for (int i = 0; i < 16; i++) check_eq("rr_oid_seq", 32'(oid_log[i]), 32'(i / 4));

        // Single requester, ten beats.
        left[2] = 10;
        repeat (20) step();
        drain();

        // Back-pressure pattern 1,0,0,1 on one streaming requester.
        ord_mode = 2;
        left[1]  = 8;
        repeat (40) step();
        drain();
        check_eq("bp_count", 32'(outcnt[1]), 32'(seq[1]));

        // Fairness: 3 arrives mid-burst of 0 and is served before 0 again.
        pulse_reset();
        oid_log.delete();
        left[0] = 12;
        step();
        step();
        left[3] = 4;
        repeat (30) step();
        drain();
        if (oid_log.size() < 9) check_eq("fair_log_size", 32'(oid_log.size()), 32'd9);
        else begin
            check_eq("fair_first", 32'(oid_log[3]), 32'd0);
            check_eq("fair_next", 32'(oid_log[4]), 32'd3);
            check_eq("fair_back", 32'(oid_log[8]), 32'd0);
        end

        // Reset mid-burst with a stalled beat; lowest active index wins afterwards.
        left[1] = 6;
        step();
        step();
        ord_mode = 0;
        repeat (3) step();
        pulse_reset();
        oid_log.delete();
        left[2] = 3;
        left[3] = 3;
        ord_mode = 1;
        repeat (20) step();
        if (oid_log.size() < 1) check_eq("post_rst_log", 32'd0, 32'd1);
        else check_eq("post_rst_first", 32'(oid_log[0]), 32'd1);
        drain();

        // Random traffic, random stalls, occasional early valid drop.
        prob = 40;
        drop = 5;
        ord_mode = 3;
        for (int i = 0; i < NREQ; i++) left[i] = 100000;
        repeat (3000) step();
        drop = 0;
        drain();
        for (int i = 0; i < NREQ; i++) check_eq("final_count", 32'(outcnt[i]), 32'(seq[i]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
